// File: rtl/emu_ff_scan_ctrl.sv
// emu_ff_scan_ctrl: checkpoint sequencer for the emulator flip-flop scan chain.
// A dump halts the DUT and rotates the chain in loopback while streaming each beat out.
// A restore halts the DUT and shifts streamed beats into the chain.
module emu_ff_scan_ctrl #(
  parameter int DATA_WIDTH  = 64,
  parameter int CHAIN_BEATS = 3,
  parameter int CNT_WIDTH   = $clog2(CHAIN_BEATS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  input  logic                  cmd_resume,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  emu_halt,
  output logic                  ff_scan,
  output logic [DATA_WIDTH-1:0] ff_sdi,
  input  logic [DATA_WIDTH-1:0] ff_sdo,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DUMP,
    ST_LOAD,
    ST_FINISH
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CHAIN_BEATS);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic                   dir_q, dir_d;
  logic                   resume_q, resume_d;
  logic                   halt_hold_q, halt_hold_d;
  logic                   done_q, done_d;
  logic [CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;

  // State register; reset releases halt so a reset mid-command frees the DUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dir_q       <= 1'b0;
      resume_q    <= 1'b0;
      halt_hold_q <= 1'b0;
      done_q      <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      resume_q    <= resume_d;
      halt_hold_q <= halt_hold_d;
      done_q      <= done_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // Next-state logic: count beats and move to FINISH on the transfer that completes the chain.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    resume_d    = resume_q;
    halt_hold_d = halt_hold_q;
    done_d      = 1'b0;
    beat_cnt_d  = beat_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          dir_d       = cmd_dir;
          resume_d    = cmd_resume;
          halt_hold_d = 1'b1;
          beat_cnt_d  = '0;
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        state_d = dir_q ? ST_LOAD : ST_DUMP;
      end
      ST_DUMP: begin
        if (out_ready) begin
          beat_cnt_d = beat_cnt_q + ONE_CNT;
          if (beat_cnt_d == LAST_CNT) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          beat_cnt_d = beat_cnt_q + ONE_CNT;
          if (beat_cnt_d == LAST_CNT) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        if (resume_q) begin
          halt_hold_d = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scan-port and stream outputs; the ready/valid to ff_scan paths stay combinational so the shift lands in the transfer cycle.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    done      = done_q;
    beat_cnt  = beat_cnt_q;
    emu_halt  = halt_hold_q || (state_q != ST_IDLE);
    ff_scan   = 1'b0;
    ff_sdi    = ff_sdo;
    out_valid = 1'b0;
    out_data  = ff_sdo;
    in_ready  = 1'b0;
    if (state_q == ST_DUMP) begin
      out_valid = 1'b1;
      ff_scan   = out_ready;
    end else if (state_q == ST_LOAD) begin
      in_ready = 1'b1;
      ff_sdi   = in_data;
      ff_scan  = in_valid;
    end
  end

endmodule

// File: tb/tb_emu_ff_scan_ctrl.sv
// Testbench for emu_ff_scan_ctrl: a behavioural scan-chain DUT, a command-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_emu_ff_scan_ctrl;

  localparam int DW = 64;
  localparam int NB = 3;
  localparam int CW = $clog2(NB + 1);

  localparam logic [DW-1:0] VA = 64'hA0A0_0000_0000_0001;
  localparam logic [DW-1:0] VB = 64'hB0B0_0000_0000_0002;
  localparam logic [DW-1:0] VC = 64'hC0C0_0000_0000_0003;
  localparam logic [DW-1:0] VX = 64'h1234_5678_9ABC_DEF0;
  localparam logic [DW-1:0] VY = 64'h0FED_CBA9_8765_4321;
  localparam logic [DW-1:0] VZ = 64'h5555_AAAA_3333_CCCC;

  localparam int P_IDLE   = 0;
  localparam int P_SETTLE = 1;
  localparam int P_DUMP   = 2;
  localparam int P_LOAD   = 3;
  localparam int P_FINISH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid, cmd_dir, cmd_resume, out_ready, in_valid;
  logic [DW-1:0] in_data;
  logic          cmd_ready, busy, done, emu_halt, ff_scan, out_valid, in_ready;
  logic [CW-1:0] beat_cnt;
  logic [DW-1:0] ff_sdi, ff_sdo, out_data;

  int vectors = 0;
  int miscompares = 0;

  // emulated DUT flip-flop chain; chain[0] is the beat presented on SDO
  logic [DW-1:0] chain [NB];
  logic [DW-1:0] run_d [NB];
  logic          run_en;

  // reference model state
  int m_phase, m_cnt;
  bit m_halt, m_dir, m_resume;

  logic [DW-1:0] cap [$];
  logic [DW-1:0] saved [NB];
  int            scans = 0;

  // sampled values from the last applyStimulus call
  logic          s_cmd_ready, s_in_ready, s_busy, s_done, s_halt, s_scan;
  logic [DW-1:0] s_out_data;

  always #5 clk = ~clk;

  emu_ff_scan_ctrl #(.DATA_WIDTH(DW), .CHAIN_BEATS(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .cmd_resume(cmd_resume),
    .busy(busy), .done(done), .beat_cnt(beat_cnt),
    .emu_halt(emu_halt), .ff_scan(ff_scan), .ff_sdi(ff_sdi), .ff_sdo(ff_sdo),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  assign ff_sdo = chain[0];

  // scan chain: shift toward SDO when scanning, otherwise capture new d values while running
  always @(posedge clk) begin
    if (ff_scan) begin
      for (int i = 0; i < NB - 1; i++) chain[i] <= chain[i + 1];
      chain[NB - 1] <= ff_sdi;
    end else if (run_en && !emu_halt) begin
      for (int i = 0; i < NB; i++) chain[i] <= run_d[i];
    end
  end

  // command-level reference model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE;
      m_cnt   = 0;
      m_halt  = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: if (cmd_valid) begin
          m_dir = cmd_dir; m_resume = cmd_resume; m_halt = 1'b1; m_cnt = 0; m_phase = P_SETTLE;
        end
        P_SETTLE: m_phase = m_dir ? P_LOAD : P_DUMP;
        P_DUMP: if (out_ready) begin
          m_cnt++;
          if (m_cnt == NB) m_phase = P_FINISH;
        end
        P_LOAD: if (in_valid) begin
          m_cnt++;
          if (m_cnt == NB) m_phase = P_FINISH;
        end
        default: begin
          if (m_resume) m_halt = 1'b0;
          m_phase = P_IDLE;
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle compare of DUT outputs against the model; also records stream beats and shifts
  always @(negedge clk) begin
    logic exp_scan;
    exp_scan = (m_phase == P_DUMP) ? out_ready : (m_phase == P_LOAD) ? in_valid : 1'b0;
    checkOutput("cmd_ready", DW'(cmd_ready), DW'(m_phase == P_IDLE));
    checkOutput("busy", DW'(busy), DW'(m_phase != P_IDLE));
    checkOutput("done", DW'(done), DW'(m_phase == P_FINISH));
    checkOutput("beat_cnt", DW'(beat_cnt), DW'(m_cnt));
    checkOutput("emu_halt", DW'(emu_halt), DW'(m_halt || m_phase != P_IDLE));
    checkOutput("ff_scan", DW'(ff_scan), DW'(exp_scan));
    checkOutput("ff_sdi", ff_sdi, (m_phase == P_LOAD) ? in_data : chain[0]);
    checkOutput("out_valid", DW'(out_valid), DW'(m_phase == P_DUMP));
    checkOutput("in_ready", DW'(in_ready), DW'(m_phase == P_LOAD));
    if (m_phase == P_DUMP) checkOutput("out_data", out_data, chain[0]);
    if (out_valid && out_ready) cap.push_back(out_data);
    if (ff_scan) scans++;
  end

  // one clock cycle of stimulus; samples outputs mid-cycle, returns just after the edge
  task automatic applyStimulus(input logic cv, input logic dir, input logic res,
                               input logic ordy, input logic ivld, input logic [DW-1:0] idata);
    cmd_valid = cv; cmd_dir = dir; cmd_resume = res;
    out_ready = ordy; in_valid = ivld; in_data = idata;
    #1;
    s_cmd_ready = cmd_ready; s_in_ready = in_ready; s_busy = busy;
    s_done = done; s_halt = emu_halt; s_scan = ff_scan; s_out_data = out_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [DW-1:0] expv [NB];
    logic [CW-1:0] cnt_exp [5];
    logic          pat [5];
    int            k, s0;

    cmd_valid = 0; cmd_dir = 0; cmd_resume = 0; out_ready = 0; in_valid = 0; in_data = '0;
    run_en = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("reset cmd_ready", DW'(cmd_ready), 1);
    checkOutput("reset busy", DW'(busy), 0);
    checkOutput("reset emu_halt", DW'(emu_halt), 0);
    checkOutput("reset beat_cnt", DW'(beat_cnt), 0);

    // let the DUT run one cycle to load its chain
    run_d[0] = VA; run_d[1] = VB; run_d[2] = VC;
    run_en = 1;
    applyStimulus(0, 0, 0, 0, 0, '0);
    run_en = 0;
    expv[0] = VA; expv[1] = VB; expv[2] = VC;

    $display("[TB] test 1: full dump, out_ready steady");
    cap.delete();
    applyStimulus(1, 0, 1, 1, 0, '0);
    checkOutput("t1 accept ready", DW'(s_cmd_ready), 1);
    applyStimulus(0, 0, 0, 1, 0, '0);
    checkOutput("t1 settle halt", DW'(s_halt), 1);
    checkOutput("t1 settle scan", DW'(s_scan), 0);
    for (int i = 0; i < NB; i++) begin
      applyStimulus(0, 0, 0, 1, 0, '0);
      checkOutput("t1 beat data", s_out_data, expv[i]);
      checkOutput("t1 beat scan", DW'(s_scan), 1);
    end
    applyStimulus(0, 0, 0, 1, 0, '0);
    checkOutput("t1 finish done", DW'(s_done), 1);
    checkOutput("t1 finish halt", DW'(s_halt), 1);
    checkOutput("t1 post halt", DW'(emu_halt), 0);
    checkOutput("t1 beat count", DW'(cap.size()), NB);
    for (int i = 0; i < NB; i++) checkOutput("t1 chain intact", chain[i], expv[i]);

    $display("[TB] test 2: dump with out_ready stalls");
    cap.delete();
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1;
    cnt_exp[0] = 1; cnt_exp[1] = 1; cnt_exp[2] = 1; cnt_exp[3] = 2; cnt_exp[4] = 3;
    applyStimulus(1, 0, 1, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, pat[i], 0, '0);
      checkOutput("t2 scan pattern", DW'(s_scan), DW'(pat[i]));
      checkOutput("t2 beat_cnt", DW'(beat_cnt), DW'(cnt_exp[i]));
    end
    applyStimulus(0, 0, 0, 0, 0, '0);
    checkOutput("t2 done", DW'(s_done), 1);
    checkOutput("t2 beat_cnt held", DW'(beat_cnt), 3);
    checkOutput("t2 beat count", DW'(cap.size()), NB);
    for (int i = 0; i < NB && i < cap.size(); i++) checkOutput("t2 beats", cap[i], expv[i]);

    $display("[TB] test 3: dump without resume, then restore");
    cap.delete();
    applyStimulus(1, 0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 1, 0, '0);
    for (int i = 0; i < NB; i++) applyStimulus(0, 0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0);
    checkOutput("t3 halt kept", DW'(emu_halt), 1);
    for (int i = 0; i < NB; i++) saved[i] = (i < cap.size()) ? cap[i] : '0;
    run_d[0] = VX; run_d[1] = VY; run_d[2] = VZ;
    run_en = 1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0, '0);
      checkOutput("t3 halt between", DW'(s_halt), 1);
    end
    run_en = 0;
    applyStimulus(1, 1, 1, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0);
    for (int i = 0; i < NB; i++) begin
      applyStimulus(0, 0, 0, 0, 1, saved[i]);
      checkOutput("t3 load halt", DW'(s_halt), 1);
    end
    applyStimulus(0, 0, 0, 0, 0, '0);
    checkOutput("t3 finish done", DW'(s_done), 1);
    checkOutput("t3 finish halt", DW'(s_halt), 1);
    checkOutput("t3 halt released", DW'(emu_halt), 0);
    for (int i = 0; i < NB; i++) checkOutput("t3 chain restored", chain[i], expv[i]);

    $display("[TB] test 4: restore with in_valid gaps");
    expv[0] = VX; expv[1] = VY; expv[2] = VZ;
    pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 1;
    applyStimulus(1, 1, 1, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0);
    s0 = scans;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, pat[i], pat[i] ? expv[k] : 64'hDEAD_BEEF_DEAD_BEEF);
      checkOutput("t4 scan pattern", DW'(s_scan), DW'(pat[i]));
      checkOutput("t4 no early done", DW'(s_done), 0);
      if (pat[i]) k++;
    end
    applyStimulus(0, 0, 0, 0, 0, '0);
    checkOutput("t4 done", DW'(s_done), 1);
    checkOutput("t4 shift count", DW'(scans - s0), 3);
    for (int i = 0; i < NB; i++) checkOutput("t4 chain loaded", chain[i], expv[i]);

    $display("[TB] test 5: commands and restore data ignored during dump");
    cap.delete();
    applyStimulus(1, 0, 1, 1, 0, '0);
    applyStimulus(0, 0, 0, 1, 0, '0);
    for (int i = 0; i < NB; i++) begin
      applyStimulus(1, 1, 0, 1, 1, 64'hFFFF_0000_FFFF_0000);
      checkOutput("t5 cmd_ready busy", DW'(s_cmd_ready), 0);
      checkOutput("t5 in_ready dump", DW'(s_in_ready), 0);
    end
    applyStimulus(0, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0);
    checkOutput("t5 idle busy", DW'(s_busy), 0);
    checkOutput("t5 idle ready", DW'(s_cmd_ready), 1);
    for (int i = 0; i < NB && i < cap.size(); i++) checkOutput("t5 beats", cap[i], expv[i]);
    for (int i = 0; i < NB; i++) checkOutput("t5 chain intact", chain[i], expv[i]);

    $display("[TB] test 6: reset mid-dump");
    applyStimulus(1, 0, 1, 1, 0, '0);
    applyStimulus(0, 0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 1, 0, '0);
    rst_n = 1'b0;
    #1;
    checkOutput("t6 halt drop", DW'(emu_halt), 0);
    checkOutput("t6 scan drop", DW'(ff_scan), 0);
    checkOutput("t6 out_valid drop", DW'(out_valid), 0);
    checkOutput("t6 busy drop", DW'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("t6 cmd_ready", DW'(cmd_ready), 1);
    checkOutput("t6 beat_cnt", DW'(beat_cnt), 0);
    checkOutput("t6 chain0 rotated", chain[0], VZ);
    checkOutput("t6 chain1 rotated", chain[1], VX);
    checkOutput("t6 chain2 rotated", chain[2], VY);
    applyStimulus(0, 0, 0, 0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
